serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Parametrised multi-cycle subtractor, successor to the 1-bit half subtractor.
//  Computes diff = a - b - bin over WIDTH bits, DIGIT bits per clock, rippling
//  the borrow through a register between cycles. Sits between producer and
//  consumer stages with valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT  2  bits processed per cycle (1 = bit-serial, WIDTH = single-cycle)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands this cycle
//  a          in   WIDTH  minuend (unsigned; two's complement when overflow flag is built)
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in
//  out_valid  out  1      result valid, held until accepted
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow-out; 1 when a < b + bin as unsigned values
//  ovf        out  1      signed overflow, present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0.
//    Borrow and digit counter are cleared. Asserting reset mid-operation
//    aborts the operation and discards the partial result.
//  - FSM IDLE -> BUSY -> DONE:
//    IDLE: in_ready=1. When in_valid=1, latch a, b and bin, clear cnt, go to BUSY.
//    BUSY: in_ready=0, out_valid=0. Each cycle, digit cnt computes
//      {brw', d} = a[cnt] - b[cnt] - brw and writes d into diff[cnt*DIGIT +: DIGIT].
//      Stay in BUSY for NDIG = WIDTH/DIGIT cycles. On cnt = NDIG-1, go to DONE.
//    DONE: out_valid=1. diff and bout are stable until the handshake completes.
//      out_ready=0: stay in DONE.
//      out_ready=1, in_valid=0: go to IDLE.
//      out_ready=1, in_valid=1: back-to-back case. in_ready=1, latch the new
//        operands and go directly to BUSY.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). in_valid is ignored
//    while in BUSY.
//  - Latency: from the in_valid & in_ready edge, out_valid rises NDIG clocks later.
//    Best-case throughput is one result per NDIG+1 cycles.
//  - Arithmetic: all results wrap modulo 2^WIDTH. bout is the borrow out of the
//    final digit.
//    Examples: 0 - 0 - 1 = all ones with bout=1; a = b with bin=0 gives diff=0, bout=0.
//  - Operand inputs may change freely after acceptance; only the latched copies are used.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//    Adds output port ovf, registered in the same cycle as the final digit.
//    ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using latched operands.
//    Reset value 0.
//  SERIAL_SUB_OVF_EN undefined:
//    No ovf port and no associated logic. All other behaviour is identical.
// STRUCTURE
//  - Package serial_sub_pkg: state_t enum {IDLE, BUSY, DONE}.
//  - Sub-module sub_digit #(DIGIT): combinational DIGIT-bit borrow-ripple slice
//    (inputs a, b, bin; outputs d, bout), built as a chain of full subtractors.
//    The top level instantiates one slice and time-multiplexes it across digits.
//  - Elaboration check: $error if WIDTH % DIGIT != 0 or DIGIT < 1.
// TESTING  (WIDTH=8, DIGIT=2 unless noted)
//  1. a=8'h5A, b=8'h3C, bin=0 -> after exactly 4 clocks: out_valid=1,
//     diff=8'h1E, bout=0.
//  2. a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'h00, b=8'h00,
//     bin=1 -> diff=8'hFF, bout=1.
//  3. Backpressure: hold out_ready=0 for 5 cycles after out_valid rises ->
//     diff/bout stable, in_ready=0. Then out_ready=1 with in_valid=1
//     (a=8'h10, b=8'h01) -> accepted the same cycle; next result is
//     diff=8'h0F, bout=0.
//  4. Assert rst during BUSY cycle 2 -> out_valid=0, in_ready=1, diff=0
//     immediately. A fresh 8'h09 - 8'h03 then gives diff=8'h06, bout=0.
//  5. With SERIAL_SUB_OVF_EN: 8'h80 - 8'h01 -> diff=8'h7F, ovf=1;
//     8'h7F - 8'h01 -> diff=8'h7E, ovf=0.
//  6. Random sweep at DIGIT=1, 4 and 8 (WIDTH=8), 1000 vectors each, compared
//     against a golden {bout,diff} = {1'b0,a} - b - bin; latency = WIDTH/DIGIT.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types for the digit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/sub_digit.sv
// sub_digit: combinational DIGIT-bit borrow-ripple subtractor slice
module sub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);
  logic [DIGIT:0] c;
  assign c[0] = bin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    assign d[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (~a[i] & (b[i] | c[i])) | (b[i] & c[i]);
  end
  assign bout = c[DIGIT];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: a - b - bin, DIGIT bits per clock, valid/ready on both sides;
// SERIAL_SUB_OVF_EN adds the signed-overflow output ovf
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic brw, accept, last, bo;
  logic [DIGIT-1:0] d;
  // operands shift right each cycle so the shared slice always sees the current digit at the bottom
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a(a_q[DIGIT-1:0]),
    .b(b_q[DIGIT-1:0]),
    .bin(brw),
    .d(d),
    .bout(bo)
  );
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    accept   = in_valid && in_ready;
    last     = state == BUSY && cnt == CW'(NDIG - 1);
    state_n  = accept ? BUSY : last ? DONE : (state == DONE && out_ready) ? IDLE : state;
  end
  assign out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        brw <= bin;
        cnt <= '0;
      end else if (state == BUSY) begin
        a_q  <= a_q >> DIGIT;
        b_q  <= b_q >> DIGIT;
        brw  <= bo;
        cnt  <= cnt + 1'b1;
        diff <= WIDTH'({d, diff} >> DIGIT);
        if (last) begin
          bout <= bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf  <= (a_q[DIGIT-1] ^ b_q[DIGIT-1]) & (d[DIGIT-1] ^ a_q[DIGIT-1]);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (directed at DIGIT=2, random sweep at DIGIT=1/4/8)
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0, sweep_go = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, bout;
  logic [7:0] diff;
  logic [9:0] q[$];
  logic [9:0] exp_m;
  int errors = 0, checks = 0;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [8:0] r;
    r = {1'b0, x} - {1'b0, y} - 9'(bi);
    return {(x[7] ^ y[7]) & (r[7] ^ x[7]), r};
  endfunction

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic bi);
    int n = 0;
    in_valid = 1'b1; a = x; b = y; bin = bi;
    while (!in_ready && n < 40) begin tick(); n++; end
    check("accept", in_ready, 1);
    q.push_back(model(x, y, bi));
    tick();
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check(tag, out_valid, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        exp_m = q.pop_front();
        check("result", {bout, diff}, exp_m[8:0]);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", ovf, exp_m[9]);
`endif
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int DG = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    logic iv = 1'b0, orr = 1'b0, bi = 1'b0, done = 1'b0;
    logic ir, ov, bo;
    logic [7:0] x = '0, y = '0, d;
    logic [9:0] sq[$];
    logic [9:0] e;
`ifdef SERIAL_SUB_OVF_EN
    logic o;
`endif
    serial_subtractor #(.WIDTH(8), .DIGIT(DG)) u_sw (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
      .a(x), .b(y), .bin(bi), .out_valid(ov), .out_ready(orr),
      .diff(d), .bout(bo)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(o)
`endif
    );
    initial begin
      wait (sweep_go);
      for (int k = 0; k < 1000; k++) begin
        int n;
        x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
        iv = 1'b1;
        check($sformatf("sw%0d_in_ready", DG), ir, 1);
        sq.push_back(model(x, y, bi));
        tick();
        iv = 1'b0; x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
        n = 0;
        while (!ov && n < 20) begin tick(); n++; end
        check($sformatf("sw%0d_latency", DG), n, 8 / DG);
        repeat ($urandom_range(0, 2)) tick();
        orr = 1'b1;
        tick();
        orr = 1'b0;
      end
      done = 1'b1;
    end
    always @(negedge clk) begin
      if (!rst && ov && orr) begin
        check($sformatf("sw%0d_nonempty", DG), sq.size() != 0, 1);
        if (sq.size() != 0) begin
          e = sq.pop_front();
          check($sformatf("sw%0d_result", DG), {bo, d}, e[8:0]);
        end
      end
    end
  end

  initial begin
    int n;
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    repeat (2) tick();
    rst = 1'b0;
    tick();
    // exact latency with the result held
    send(8'h5A, 8'h3C, 1'b0);
    repeat (3) tick();
    check("lat_early", out_valid, 0);
    tick();
    check("lat_exact", out_valid, 1);
    check("t1_diff", diff, 8'h1E);
    check("t1_bout", bout, 0);
    out_ready = 1'b1;
    tick();
    // borrow cases, back to back
    send(8'h00, 8'h01, 1'b0);
    send(8'h00, 8'h00, 1'b1);
    wait_valid("t2_valid");
    tick();
    // backpressure then same-cycle reload
    out_ready = 1'b0;
    send(8'hA5, 8'h5A, 1'b1);
    wait_valid("t3_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_diff", {bout, diff}, q[0][8:0]);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    send(8'h10, 8'h01, 1'b0);
    check("reload_busy", out_valid, 0);
    wait_valid("t3b_valid");
    tick();
    // reset mid-operation
    send(8'h77, 8'h22, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_diff", diff, 0);
    q.delete();
    rst = 1'b0;
    tick();
    send(8'h09, 8'h03, 1'b0);
    wait_valid("t4_valid");
    tick();
    // signed overflow vectors
    send(8'h80, 8'h01, 1'b0);
    send(8'h7F, 8'h01, 1'b0);
    wait_valid("t5_valid");
    tick();
    tick();
    check("main_sb_empty", q.size(), 0);
    sweep_go = 1'b1;
    n = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && n < 40000) begin tick(); n++; end
    check("sweep_done", g_sw[0].done && g_sw[1].done && g_sw[2].done, 1);
    tick();
    check("sweep_sb_empty", g_sw[0].sq.size() + g_sw[1].sq.size() + g_sw[2].sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
